// File: rtl/vector_mem_sequencer_pkg.sv
// Shared definitions for the vector memory sequencer: FSM state encoding and default geometry.
package asip_mem_pkg;

  localparam int DEF_VEC_SIZE = 4;
  localparam int DEF_REG_SIZE = 8;
  localparam int LANE_W       = $clog2(DEF_VEC_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } seq_state_t;

  // States in which the sequencer owns the memory port and the pipeline must hold.
  function automatic logic is_busy(seq_state_t s);
    return (s == WRITE) || (s == READ) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/vector_mem_sequencer_if.sv
// Request/response and data-RAM bus of the vector memory sequencer.
interface vector_mem_sequencer_if
  import asip_mem_pkg::*;
#(
  parameter int vecSize      = DEF_VEC_SIZE,
  parameter int registerSize = DEF_REG_SIZE
);

  logic                             req_valid;
  logic                             req_write;
  logic [registerSize-1:0]          req_addr;
  logic [vecSize*registerSize-1:0]  req_data;
  logic                             req_ready;
  logic                             stall;
  logic [registerSize-1:0]          mem_addr;
  logic                             mem_we;
  logic [registerSize-1:0]          mem_wdata;
  logic [registerSize-1:0]          mem_rdata;
  logic                             rsp_valid;
  logic [vecSize*registerSize-1:0]  rsp_data;

  // Sequencer side.
  modport slave (
    input  req_valid, req_write, req_addr, req_data, mem_rdata,
    output req_ready, stall, mem_addr, mem_we, mem_wdata, rsp_valid, rsp_data
  );

  // Pipeline + RAM side.
  modport master (
    output req_valid, req_write, req_addr, req_data, mem_rdata,
    input  req_ready, stall, mem_addr, mem_we, mem_wdata, rsp_valid, rsp_data
  );

endinterface

// File: rtl/vector_mem_sequencer.sv
// Sequences one vector load/store against a byte-wide single-port sync-read RAM,
// one lane per cycle, stalling the pipeline while busy.
module vector_mem_sequencer
  import asip_mem_pkg::*;
#(
  parameter int vecSize      = DEF_VEC_SIZE,
  parameter int registerSize = DEF_REG_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  vector_mem_sequencer_if.slave   bus
);

  localparam int LW = (vecSize > 1) ? $clog2(vecSize) : 1;
  localparam logic [LW-1:0] LAST = LW'(vecSize - 1);

  seq_state_t              state, state_n;
  logic [LW-1:0]           lane, lane_n;
  logic [registerSize-1:0] base_q;
  logic [registerSize-1:0] data_q [vecSize];
  logic [registerSize-1:0] rsp_q  [vecSize];
  logic                    ready;
  logic                    accept;

  assign ready  = (state == IDLE) || (state == DONE);
  assign accept = bus.req_valid && ready;

  always_comb begin
    state_n = state;
    lane_n  = lane;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_n = bus.req_write ? WRITE : READ;
          lane_n  = '0;
        end else if (state == DONE) begin
          state_n = IDLE;
        end
      end
      WRITE: begin
        if (lane == LAST) begin
          state_n = DONE;
          lane_n  = '0;
        end else begin
          lane_n = lane + LW'(1);
        end
      end
      READ: begin
        if (lane == LAST) begin
          state_n = DRAIN;
          lane_n  = '0;
        end else begin
          lane_n = lane + LW'(1);
        end
      end
      DRAIN:   state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = ready;
    bus.stall     = is_busy(state) || (ready && bus.req_valid);
    bus.rsp_valid = (state == DONE);
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (state == WRITE || state == READ) begin
      bus.mem_addr = base_q + registerSize'(lane);
    end
    if (state == WRITE) begin
      bus.mem_we    = 1'b1;
      bus.mem_wdata = data_q[lane];
    end
  end

  always_comb begin
    bus.rsp_data = '0;
    for (int unsigned i = 0; i < vecSize; i++) begin
      bus.rsp_data[i*registerSize +: registerSize] = rsp_q[i];
    end
  end

  // Sync-read RAM: data for lane k arrives while lane k+1 is addressed,
  // so capture lags by one lane and DRAIN collects the last one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      lane   <= '0;
      base_q <= '0;
      for (int unsigned i = 0; i < vecSize; i++) begin
        data_q[i] <= '0;
        rsp_q[i]  <= '0;
      end
    end else begin
      state <= state_n;
      lane  <= lane_n;
      if (accept) begin
        base_q <= bus.req_addr;
        for (int unsigned i = 0; i < vecSize; i++) begin
          data_q[i] <= bus.req_data[i*registerSize +: registerSize];
        end
      end
      if (state == READ && lane != '0) begin
        rsp_q[lane - LW'(1)] <= bus.mem_rdata;
      end
      if (state == DRAIN) begin
        rsp_q[LAST] <= bus.mem_rdata;
      end
    end
  end

endmodule
